// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: nibble-serial a - b - bin subtractor with an IDLE/RUN/DONE handshake.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           operation request, sampled only in IDLE
//   a, b, bin       minuend, subtrahend (4*NIBBLES bits) and borrow-in
//   busy            high in RUN and DONE
//   done            one-cycle completion pulse (DONE state)
//   diff, bout      registered result and final borrow
//   zero            high when the completed diff is zero
module serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
  output logic                 zero
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0]  ra, rb, res, res_nx;
  logic [IW-1:0] idx;
  logic          brw, last;
  logic [4:0]    slice;
  // Operands shift right each RUN cycle, so the active nibble is always [3:0];
  // result nibbles enter at the top and reach their place after NIBBLES shifts.
  assign slice  = {1'b0, ra[3:0]} - {1'b0, rb[3:0]} - 5'(brw);
  assign res_nx = W'({slice[3:0], res} >> 4);
  assign last   = idx == IW'(NIBBLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    busy     = state != IDLE;
    done     = state == DONE;
    if (state == IDLE) state_nx = start ? RUN : IDLE;
    else if (state == RUN) state_nx = last ? DONE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      brw  <= 1'b0;
      idx  <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      ra  <= a;
      rb  <= b;
      brw <= bin;
      idx <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 4;
      rb  <= rb >> 4;
      brw <= slice[4];
      res <= res_nx;
      if (!last) idx <= idx + 1'b1;
      if (last) begin
        diff <= res_nx;
        bout <= slice[4];
        zero <= res_nx == '0;
      end
    end
endmodule
